gin_feeder: RTL

Upstream stage of the global input network in the PE array. Accepts a plain value stream from the global-buffer reader and tags each value with a row tag (Y-bus select) and a column tag (X-bus/PE select) from a configured 2-D tile walk. It then presents `{enable, row_tag, col_tag, value}` to the network's slave port under its enable/ready handshake. A 2-entry buffer decouples the upstream ready from the network's ready.

---
 rtl/gin_pkg.sv | 20 ++
 rtl/gin_feeder_if.sv | 17 +
 rtl/gin_feeder_buf.sv | 44 ++++
 rtl/gin_feeder.sv | 87 ++++++++
 4 files changed

// File: rtl/gin_pkg.sv
// Shared widths, entry type and FSM state for the global input network feeder.
package gin_pkg;
  localparam int XBUS_NUMS = 12;
  localparam int PE_NUMS   = 14;
  localparam int ID_LEN    = 5;
  localparam int ROW_LEN   = 4;
  localparam int VALUE_LEN = 32;

  typedef struct packed {
    logic [ROW_LEN-1:0]   row;
    logic [ID_LEN-1:0]    col;
    logic [VALUE_LEN-1:0] value;
  } gin_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } gin_state_t;
endpackage

// File: rtl/gin_feeder_if.sv
// Upstream value stream plus tagged network request, as seen by the feeder (master).
interface gin_feeder_if;
  import gin_pkg::*;
  logic                 in_valid;
  logic                 in_ready;
  logic [VALUE_LEN-1:0] in_value;
  logic                 enable;
  logic                 ready;
  logic [ROW_LEN-1:0]   row_tag;
  logic [ID_LEN-1:0]    col_tag;
  logic [VALUE_LEN-1:0] value;

  modport master (input in_valid, in_value, ready,
                  output in_ready, enable, row_tag, col_tag, value);
  modport slave  (output in_valid, in_value, ready,
                  input in_ready, enable, row_tag, col_tag, value);
endinterface

// File: rtl/gin_feeder_buf.sv
// 2-entry shift FIFO; slot 0 is always the head so outputs come straight from a register.
module gin_feeder_buf import gin_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  gin_entry_t din,
  output gin_entry_t head,
  output logic [1:0] count
);
  gin_entry_t [1:0] mem;
  logic do_pop, do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          mem[count[0]] <= din;
          count         <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          // push+pop keeps the count; the new entry lands behind whatever remains
          if (count == 2'd1) mem[0] <= din;
          else begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/gin_feeder.sv
// Tags an upstream value stream with (row, col) from a 2-D tile walk and feeds the network.
module gin_feeder import gin_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ROW_LEN-1:0] cfg_row_base,
  input  logic [ROW_LEN-1:0] cfg_rows_m1,
  input  logic [ID_LEN-1:0]  cfg_col_base,
  input  logic [ID_LEN-1:0]  cfg_cols_m1,
  output logic               busy,
  output logic               done,
  gin_feeder_if.master       gin
);
  gin_state_t         state;
  logic [ROW_LEN-1:0] row_base, rows_m1, row_cnt;
  logic [ID_LEN-1:0]  col_base, cols_m1, col_cnt;
  logic [1:0]         count;
  logic               push, pop, last_col, last_row;
  gin_entry_t         din, head;

  // in_ready depends only on registered state, never on ready/in_valid
  assign gin.in_ready = (state == STREAM) && (count < 2'd2);
  assign push         = gin.in_valid && gin.in_ready;
  assign gin.enable   = (count != 2'd0);
  assign pop          = gin.enable && gin.ready;
  assign busy         = (state != IDLE);
  assign last_col     = (col_cnt == cols_m1);
  assign last_row     = (row_cnt == rows_m1);

  assign din.row   = row_base + row_cnt;
  assign din.col   = col_base + col_cnt;
  assign din.value = gin.in_value;

  assign gin.row_tag = head.row;
  assign gin.col_tag = head.col;
  assign gin.value   = head.value;

  gin_feeder_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      row_base <= '0;
      rows_m1  <= '0;
      row_cnt  <= '0;
      col_base <= '0;
      cols_m1  <= '0;
      col_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          row_base <= cfg_row_base;
          rows_m1  <= cfg_rows_m1;
          col_base <= cfg_col_base;
          cols_m1  <= cfg_cols_m1;
          row_cnt  <= '0;
          col_cnt  <= '0;
          state    <= STREAM;
        end
        STREAM: if (push) begin
          if (last_col) begin
            col_cnt <= '0;
            if (last_row) state <= DRAIN;
            else          row_cnt <= row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        DRAIN: if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
